// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, the LSU bridge FSM state type and a byte-enable mask helper.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3
    } hsize_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1
    } hburst_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR  = 2'd2
    } lsu_state_e;

    // Expand up to 8 byte enables into a 64-bit bit mask; callers truncate to their width.
    function automatic logic [63:0] be_to_mask(input logic [7:0] be);
        logic [63:0] mask;
        for (int unsigned i = 0; i < 8; i++) begin
            mask[i*8 +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/ahb_be_decode.sv
// Maps core byte enables to an AHB transfer size and low address offset.
module ahb_be_decode
    import ahb_pkg::*;
#(
    parameter int unsigned AHB_DATA_WIDTH = 32
) (
    input  logic [AHB_DATA_WIDTH/8-1:0]         be,
    output logic [2:0]                          hsize,
    output logic [$clog2(AHB_DATA_WIDTH/8)-1:0] offset
);

    localparam int unsigned NB = AHB_DATA_WIDTH / 8;
    localparam int unsigned OW = $clog2(NB);

    if (AHB_DATA_WIDTH != 32 && AHB_DATA_WIDTH != 64) begin : g_bad_width
        $error("ahb_be_decode: AHB_DATA_WIDTH must be 32 or 64");
    end

    // Anything not matching an aligned naturally-sized pattern falls back to full width at offset 0.
    always_comb begin
        hsize  = (NB == 8) ? HSIZE_DWORD : HSIZE_WORD;
        offset = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (be == (NB'(1) << i)) begin
                hsize  = HSIZE_BYTE;
                offset = OW'(i);
            end
            if ((i % 2) == 0 && be == (NB'(3) << i)) begin
                hsize  = HSIZE_HALF;
                offset = OW'(i);
            end
            if ((i % 4) == 0 && be == (NB'(15) << i)) begin
                hsize  = HSIZE_WORD;
                offset = OW'(i);
            end
        end
    end

endmodule

// File: rtl/lsu_ahb_bridge.sv
// Core load/store request port to single-transfer AHB-Lite master, one data phase pipelined.
module lsu_ahb_bridge
    import ahb_pkg::*;
#(
    parameter int unsigned AHB_ADDR_WIDTH = 32,
    parameter int unsigned AHB_DATA_WIDTH = 32,
    parameter logic [3:0]  HPROT_VAL      = 4'b0011
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        req_i,
    input  logic                        we_i,
    input  logic [AHB_DATA_WIDTH/8-1:0] be_i,
    input  logic [AHB_ADDR_WIDTH-1:0]   addr_i,
    input  logic [AHB_DATA_WIDTH-1:0]   wdata_i,
    output logic                        gnt_o,
    output logic                        rvalid_o,
    output logic [AHB_DATA_WIDTH-1:0]   rdata_o,
    output logic                        err_o,
    output logic [AHB_ADDR_WIDTH-1:0]   haddr_o,
    output logic                        hwrite_o,
    output logic [2:0]                  hsize_o,
    output logic [2:0]                  hburst_o,
    output logic [3:0]                  hprot_o,
    output logic [1:0]                  htrans_o,
    output logic                        hmastlock_o,
    output logic [AHB_DATA_WIDTH-1:0]   hwdata_o,
    input  logic [AHB_DATA_WIDTH-1:0]   hrdata_i,
    input  logic                        hready_i,
    input  logic                        hresp_i
);

    localparam int unsigned OW = $clog2(AHB_DATA_WIDTH / 8);

    lsu_state_e                state;
    lsu_state_e                state_nxt;
    logic                      first_err;
    logic                      nonseq;
    logic [OW-1:0]             be_off;
    logic [AHB_DATA_WIDTH-1:0] wdata_masked;
    logic                      dp_we;
    logic [AHB_DATA_WIDTH-1:0] dp_wdata;

    ahb_be_decode #(
        .AHB_DATA_WIDTH(AHB_DATA_WIDTH)
    ) u_be_decode (
        .be    (be_i),
        .hsize (hsize_o),
        .offset(be_off)
    );

    // Address phase follows the held request fields directly.
    assign haddr_o      = {addr_i[AHB_ADDR_WIDTH-1:OW], be_off};
    assign hwrite_o     = we_i;
    assign hburst_o     = HBURST_SINGLE;
    assign hprot_o      = HPROT_VAL;
    assign hmastlock_o  = 1'b0;
    assign rdata_o      = hrdata_i;
    assign wdata_masked = wdata_i & AHB_DATA_WIDTH'(be_to_mask(8'(be_i)));
    assign hwdata_o     = (rstn && dp_we) ? dp_wdata : '0;

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Data-phase register, loaded when the address phase completes.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            dp_we    <= 1'b0;
            dp_wdata <= '0;
        end else if (gnt_o) begin
            dp_we    <= we_i;
            dp_wdata <= we_i ? wdata_masked : '0;
        end
    end

    // Next state and handshake outputs; a pending request is cancelled across both error cycles.
    always_comb begin
        state_nxt = state;
        first_err = 1'b0;
        nonseq    = 1'b0;
        htrans_o  = HTRANS_IDLE;
        gnt_o     = 1'b0;
        rvalid_o  = 1'b0;
        err_o     = 1'b0;

        first_err = (state == ST_DATA) && hresp_i && !hready_i;
        nonseq    = rstn && req_i && (state != ST_ERR) && !first_err;
        htrans_o  = nonseq ? HTRANS_NONSEQ : HTRANS_IDLE;
        gnt_o     = nonseq && hready_i;
        rvalid_o  = rstn && (state != ST_IDLE) && hready_i;
        err_o     = rvalid_o && hresp_i;

        case (state)
            ST_IDLE: begin
                if (gnt_o) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (first_err) begin
                    state_nxt = ST_ERR;
                end else if (hready_i) begin
                    state_nxt = gnt_o ? ST_DATA : ST_IDLE;
                end
            end
            ST_ERR: begin
                if (hready_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_ahb_bridge.sv
// Self-checking bench for lsu_ahb_bridge: directed cycle checks plus a read-data scoreboard.
module tb_lsu_ahb_bridge;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam logic [31:0] PAT = 32'hCAFE0000;

    logic          clk = 1'b0;
    logic          rstn;
    logic          req_i;
    logic          we_i;
    logic [3:0]    be_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] wdata_i;
    logic          gnt_o;
    logic          rvalid_o;
    logic [DW-1:0] rdata_o;
    logic          err_o;
    logic [AW-1:0] haddr_o;
    logic          hwrite_o;
    logic [2:0]    hsize_o;
    logic [2:0]    hburst_o;
    logic [3:0]    hprot_o;
    logic [1:0]    htrans_o;
    logic          hmastlock_o;
    logic [DW-1:0] hwdata_o;
    logic [DW-1:0] hrdata_i;
    logic          hready_i;
    logic          hresp_i;

    logic [AW-1:0] slv_addr = '0;
    logic          exp_err  = 1'b0;
    logic [DW-1:0] sb[$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            rv_count = 0;

    lsu_ahb_bridge #(
        .AHB_ADDR_WIDTH(AW),
        .AHB_DATA_WIDTH(DW),
        .HPROT_VAL     (4'b0011)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_i      (req_i),
        .we_i       (we_i),
        .be_i       (be_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .gnt_o      (gnt_o),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .haddr_o    (haddr_o),
        .hwrite_o   (hwrite_o),
        .hsize_o    (hsize_o),
        .hburst_o   (hburst_o),
        .hprot_o    (hprot_o),
        .htrans_o   (htrans_o),
        .hmastlock_o(hmastlock_o),
        .hwdata_o   (hwdata_o),
        .hrdata_i   (hrdata_i),
        .hready_i   (hready_i),
        .hresp_i    (hresp_i)
    );

    always #5 clk = ~clk;

    // Slave model: read data is a function of the address captured at grant.
    always @(posedge clk) begin
        if (gnt_o) slv_addr <= haddr_o;
    end
    assign hrdata_i = slv_addr ^ PAT;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard: expected read data pushed on grant, popped on rvalid.
    always @(negedge clk) begin
        if (rvalid_o) begin
            rv_count++;
            if (sb.size() == 0) begin
                check("sb_unexpected_rvalid", 64'd1, 64'd0);
            end else begin
                check("sb_rdata", 64'(rdata_o), 64'(sb.pop_front()));
                check("sb_err", 64'(err_o), 64'(exp_err));
            end
        end
        if (gnt_o) sb.push_back(haddr_o ^ PAT);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drive(input logic we, input logic [3:0] be, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd);
        req_i   = 1'b1;
        we_i    = we;
        be_i    = be;
        addr_i  = addr;
        wdata_i = wd;
    endtask

    // Single no-wait write through the byte-enable decoder.
    task automatic wr_case(input logic [3:0] be, input logic [2:0] sz, input logic [AW-1:0] ha,
                           input logic [DW-1:0] hwd);
        cyc();
        drive(1'b1, be, 32'h20, 32'hAABBCCDD);
        smp();
        check("be_gnt", 64'(gnt_o), 64'd1);
        check("be_hsize", 64'(hsize_o), 64'(sz));
        check("be_haddr", 64'(haddr_o), 64'(ha));
        check("be_hwrite", 64'(hwrite_o), 64'd1);
        cyc();
        req_i = 1'b0;
        smp();
        check("be_hwdata", 64'(hwdata_o), 64'(hwd));
        check("be_rvalid", 64'(rvalid_o), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; hready_i = 1'b1; hresp_i = 1'b0;
        drive(1'b1, 4'hF, 32'h1000, 32'h12345678);
        repeat (2) @(posedge clk);
        smp();
        check("rst_gnt", 64'(gnt_o), 64'd0);
        check("rst_htrans", 64'(htrans_o), 64'd0);
        check("rst_rvalid", 64'(rvalid_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_hwdata", 64'(hwdata_o), 64'd0);
        cyc();
        rstn = 1'b1; req_i = 1'b0;

        // Single read, no wait states.
        cyc();
        drive(1'b0, 4'hF, 32'h1000, 32'h0);
        smp();
        check("rd_gnt", 64'(gnt_o), 64'd1);
        check("rd_htrans", 64'(htrans_o), 64'd2);
        check("rd_hsize", 64'(hsize_o), 64'd2);
        check("rd_haddr", 64'(haddr_o), 64'h1000);
        check("rd_hwrite", 64'(hwrite_o), 64'd0);
        check("rd_hburst", 64'(hburst_o), 64'd0);
        check("rd_hprot", 64'(hprot_o), 64'd3);
        check("rd_hmastlock", 64'(hmastlock_o), 64'd0);
        check("rd_rvalid0", 64'(rvalid_o), 64'd0);
        cyc();
        req_i = 1'b0;
        smp();
        check("rd_rvalid1", 64'(rvalid_o), 64'd1);
        check("rd_rdata", 64'(rdata_o), 64'(32'h1000 ^ PAT));
        check("rd_gnt1", 64'(gnt_o), 64'd0);

        // Back-to-back writes.
        cyc();
        drive(1'b1, 4'hF, 32'h10, 32'h11112222);
        smp();
        check("b2b_gnt0", 64'(gnt_o), 64'd1);
        cyc();
        drive(1'b1, 4'hF, 32'h14, 32'h33334444);
        smp();
        check("b2b_gnt1", 64'(gnt_o), 64'd1);
        check("b2b_haddr1", 64'(haddr_o), 64'h14);
        check("b2b_hwdata1", 64'(hwdata_o), 64'h11112222);
        check("b2b_rvalid1", 64'(rvalid_o), 64'd1);
        cyc();
        req_i = 1'b0;
        smp();
        check("b2b_gnt2", 64'(gnt_o), 64'd0);
        check("b2b_hwdata2", 64'(hwdata_o), 64'h33334444);
        check("b2b_rvalid2", 64'(rvalid_o), 64'd1);

        // Byte-enable decoding, legal and illegal patterns.
        wr_case(4'b0100, 3'd0, 32'h22, 32'h00BB0000);
        wr_case(4'b0001, 3'd0, 32'h20, 32'h000000DD);
        wr_case(4'b1000, 3'd0, 32'h23, 32'hAA000000);
        wr_case(4'b0011, 3'd1, 32'h20, 32'h0000CCDD);
        wr_case(4'b1100, 3'd1, 32'h22, 32'hAABB0000);
        wr_case(4'b1111, 3'd2, 32'h20, 32'hAABBCCDD);
        wr_case(4'b0110, 3'd2, 32'h20, 32'h00BBCC00);
        wr_case(4'b0101, 3'd2, 32'h20, 32'h00BB00DD);
        wr_case(4'b0000, 3'd2, 32'h20, 32'h00000000);

        // Read with three wait states while a write request is held.
        cyc();
        drive(1'b0, 4'hF, 32'h40, 32'h0);
        smp();
        check("ws_gnt0", 64'(gnt_o), 64'd1);
        cyc();
        drive(1'b1, 4'hF, 32'h44, 32'h5555AAAA);
        hready_i = 1'b0;
        for (int w = 0; w < 3; w++) begin
            smp();
            check("ws_rvalid", 64'(rvalid_o), 64'd0);
            check("ws_gnt", 64'(gnt_o), 64'd0);
            check("ws_htrans", 64'(htrans_o), 64'd2);
            check("ws_haddr", 64'(haddr_o), 64'h44);
            check("ws_hwrite", 64'(hwrite_o), 64'd1);
            check("ws_hwdata", 64'(hwdata_o), 64'd0);
            if (w < 2) cyc();
        end
        cyc();
        hready_i = 1'b1;
        smp();
        check("ws_rvalid4", 64'(rvalid_o), 64'd1);
        check("ws_rdata4", 64'(rdata_o), 64'(32'h40 ^ PAT));
        check("ws_gnt4", 64'(gnt_o), 64'd1);
        cyc();
        req_i = 1'b0;
        smp();
        check("ws_wr_rvalid", 64'(rvalid_o), 64'd1);
        check("ws_wr_hwdata", 64'(hwdata_o), 64'h5555AAAA);

        // Two-cycle error response with a second request pending.
        cyc();
        drive(1'b0, 4'hF, 32'h80, 32'h0);
        smp();
        check("er_gnt0", 64'(gnt_o), 64'd1);
        cyc();
        drive(1'b0, 4'hF, 32'h84, 32'h0);
        hready_i = 1'b0; hresp_i = 1'b1;
        smp();
        check("er_htrans1", 64'(htrans_o), 64'd0);
        check("er_gnt1", 64'(gnt_o), 64'd0);
        check("er_rvalid1", 64'(rvalid_o), 64'd0);
        cyc();
        hready_i = 1'b1; exp_err = 1'b1;
        smp();
        check("er_htrans2", 64'(htrans_o), 64'd0);
        check("er_gnt2", 64'(gnt_o), 64'd0);
        check("er_rvalid2", 64'(rvalid_o), 64'd1);
        check("er_err2", 64'(err_o), 64'd1);
        cyc();
        hresp_i = 1'b0; exp_err = 1'b0;
        smp();
        check("er_htrans3", 64'(htrans_o), 64'd2);
        check("er_gnt3", 64'(gnt_o), 64'd1);
        check("er_haddr3", 64'(haddr_o), 64'h84);
        check("er_rvalid3", 64'(rvalid_o), 64'd0);
        cyc();
        req_i = 1'b0;
        smp();
        check("er_rvalid4", 64'(rvalid_o), 64'd1);
        check("er_err4", 64'(err_o), 64'd0);

        // Reset during an outstanding data phase.
        cyc();
        drive(1'b0, 4'hF, 32'h100, 32'h0);
        smp();
        check("mr_gnt0", 64'(gnt_o), 64'd1);
        cyc();
        req_i = 1'b0; hready_i = 1'b0; rstn = 1'b0;
        smp();
        check("mr_rvalid1", 64'(rvalid_o), 64'd0);
        cyc();
        rstn = 1'b1; hready_i = 1'b1;
        smp();
        check("mr_rvalid2", 64'(rvalid_o), 64'd0);
        check("mr_htrans2", 64'(htrans_o), 64'd0);
        check("mr_err2", 64'(err_o), 64'd0);
        sb.delete();
        cyc();
        drive(1'b0, 4'hF, 32'h104, 32'h0);
        smp();
        check("mr_gnt3", 64'(gnt_o), 64'd1);
        cyc();
        req_i = 1'b0;
        smp();
        check("mr_rvalid4", 64'(rvalid_o), 64'd1);

        cyc();
        smp();
        check("sb_drain", 64'(sb.size()), 64'd0);
        check("rvalid_total", 64'(rv_count), 64'd17);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lsu_ahb_bridge.md
LSU_AHB_BRIDGE -- requirements
Module: lsu_ahb_bridge

Interface
REQ-001 SHALL have parameter AHB_ADDR_WIDTH, default 32: width of haddr_o and addr_i.
REQ-002 SHALL have parameter AHB_DATA_WIDTH, default 32: core and bus data width; legal values are 32 and 64.
REQ-003 SHALL have parameter HPROT_VAL, default 4'b0011: constant driven on hprot_o.
REQ-004 SHALL have port clk, input, 1: clock.
REQ-005 SHALL have port rstn, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port req_i, input, 1: core request; the core holds it and all request fields stable until gnt_o.
REQ-007 SHALL have port we_i, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have port be_i, input, AHB_DATA_WIDTH/8: byte enables.
REQ-009 SHALL have port addr_i, input, AHB_ADDR_WIDTH: bus-aligned word address.
REQ-010 SHALL have port wdata_i, input, AHB_DATA_WIDTH: write data.
REQ-011 SHALL have port gnt_o, output, 1: request accepted, meaning the address phase completed.
REQ-012 SHALL have port rvalid_o, output, 1: data phase complete; one pulse per grant.
REQ-013 SHALL have port rdata_o, output, AHB_DATA_WIDTH: read data, valid with rvalid_o.
REQ-014 SHALL have port err_o, output, 1: bus error, valid with rvalid_o.
REQ-015 SHALL have port haddr_o, output, AHB_ADDR_WIDTH: AHB address.
REQ-016 SHALL have ports hwrite_o (1), hsize_o (3), hburst_o (3), hprot_o (4), htrans_o (2) and hmastlock_o (1), all outputs: AHB control.
REQ-017 SHALL have port hwdata_o, output, AHB_DATA_WIDTH: AHB write data.
REQ-018 SHALL have ports hrdata_i (AHB_DATA_WIDTH), hready_i (1) and hresp_i (1), all inputs: AHB slave response.

Function
REQ-019 SHALL drive hburst_o=SINGLE, hmastlock_o=0 and hprot_o=HPROT_VAL at all times.
REQ-020 SHALL implement FSM states IDLE, DATA (one data phase outstanding) and ERR (second error cycle pending).
REQ-021 SHALL drive htrans_o=NONSEQ when req_i=1, state≠ERR, and no first-error cycle (DATA & hresp_i & ~hready_i) is present; otherwise it SHALL drive IDLE.
REQ-022 SHALL assert gnt_o = (htrans_o==NONSEQ) & hready_i, with zero latency from hready_i.
REQ-023 SHALL capture we, size, byte lane mask and wdata&bytemask into the data-phase register on gnt_o, and SHALL drive hwdata_o from that register during the data phase.
REQ-024 SHALL implement the transitions IDLE->DATA on gnt; DATA->DATA on hready_i & gnt (back-to-back pipelining); DATA->IDLE on hready_i & ~gnt; DATA->ERR on hresp_i & ~hready_i; ERR->IDLE on hready_i.
REQ-025 SHALL pulse rvalid_o in DATA or ERR when hready_i=1, with err_o=hresp_i and rdata_o=hrdata_i passed unmodified (full lane).
REQ-026 SHALL decode hsize/haddr low bits from be_i: a single byte -> BYTE at that byte offset; an aligned contiguous pair -> HALF; an aligned contiguous quad -> WORD; all ones at width 64 -> DWORD.
REQ-027 SHALL treat an illegal be_i (non-contiguous, misaligned, or all-zero) as a full-width transfer at the aligned address, with hwdata masked by be_i.
REQ-028 SHALL block new grants during the first error cycle and in ERR, cancelling any pending request; the request SHALL be re-issued only after the error response completes.
REQ-029 SHALL hold all outputs stable while hready_i=0 (wait states), except htrans_o during error cancellation.

Reset
REQ-030 SHALL, while rstn=0 at a clk edge, set state=IDLE and the data-phase register to 0; at the same time gnt_o=rvalid_o=err_o=0, htrans_o=IDLE and hwdata_o=0.
REQ-031 SHALL, when reset is applied mid-transfer, drop the outstanding data phase with no rvalid_o.

Structure
REQ-032 SHALL take the HTRANS, HSIZE and HBURST encodings and the FSM state enum from shared package ahb_pkg.
REQ-033 SHALL implement be_i -> {hsize, addr offset} decoding in sub-module ahb_be_decode, which is parametrised by AHB_DATA_WIDTH.

Verification
REQ-034 Bench SHALL cover: a single read of 0x1000 with be=1111 and hready_i=1 -> gnt in cycle 0, htrans NONSEQ, hsize WORD; rvalid in cycle 1 with rdata=hrdata_i.
REQ-035 Bench SHALL cover: back-to-back writes to 0x10 and 0x14 with no wait states -> gnt in cycles 0 and 1, hwdata_o = first data in cycle 1 and second data in cycle 2, two rvalid pulses.
REQ-036 Bench SHALL cover: a write with be=0100 and data 0xAABBCCDD -> haddr low bits=2, hsize BYTE, hwdata=0x00BB0000.
REQ-037 Bench SHALL cover: a read with hready_i=0 for 3 cycles -> rvalid only in the 4th data cycle and outputs stable throughout.
REQ-038 Bench SHALL cover: hresp_i=1 with hready_i=0, then hresp_i=1 with hready_i=1, while a second req is pending -> htrans IDLE in both cycles, rvalid with err_o=1, second request granted afterwards.
REQ-039 Bench SHALL cover: rstn=0 asserted during DATA -> no rvalid, state IDLE, htrans IDLE on the next cycle.
